// File: rtl/carpma_hakem.sv
// carpma_hakem: round-robin arbiter and result router sharing one carpma_birimi between two requesters
// Ports: clk_i/rst_i clock and sync active-high reset; istek* request side (valid/ready, op, operands, tag);
// iptal_i flushes requester-0 work; sonuc* result side; cb_* drive the multiplier and read its result.
module carpma_hakem #(
  parameter int GECIKME  = 1,
  parameter int ETIKET_W = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [1:0]          istek_gecerli_i,
  output logic [1:0]          istek_hazir_o,
  input  logic [1:0]          istek0_kontrol_i,
  input  logic [31:0]         istek0_deger1_i,
  input  logic [31:0]         istek0_deger2_i,
  input  logic [ETIKET_W-1:0] istek0_etiket_i,
  input  logic [1:0]          istek1_kontrol_i,
  input  logic [31:0]         istek1_deger1_i,
  input  logic [31:0]         istek1_deger2_i,
  input  logic [ETIKET_W-1:0] istek1_etiket_i,
  input  logic                iptal_i,
  output logic [1:0]          sonuc_gecerli_o,
  input  logic [1:0]          sonuc_hazir_i,
  output logic [31:0]         sonuc_o,
  output logic [ETIKET_W-1:0] sonuc_etiket_o,
  output logic                cb_durdur_o,
  output logic [1:0]          cb_kontrol_o,
  output logic [31:0]         cb_deger1_o,
  output logic [31:0]         cb_deger2_o,
  input  logic [31:0]         cb_sonuc_i
);
  localparam int L = GECIKME - 1;
  logic [GECIKME-1:0] gecerli_q, gecerli_d, sahip_q, sahip_d;
  logic [GECIKME-1:0][ETIKET_W-1:0] etiket_q, etiket_d;
  logic ptr_q, ptr_d;
  logic son_iptal, g0, g1, aktar;
  always_comb begin
    // a flushed requester-0 result at the tail neither presents nor stalls the pipe
    son_iptal = iptal_i && !sahip_q[L];
    cb_durdur_o = gecerli_q[L] && !sonuc_hazir_i[sahip_q[L]] && !son_iptal;
    sonuc_gecerli_o = (gecerli_q[L] && !son_iptal) ? (sahip_q[L] ? 2'b10 : 2'b01) : 2'b00;
    sonuc_o = cb_sonuc_i;
    sonuc_etiket_o = etiket_q[L];
    g1 = istek_gecerli_i[1] && (!(istek_gecerli_i[0] && !iptal_i) || ptr_q);
    g0 = istek_gecerli_i[0] && !iptal_i && !g1;
    istek_hazir_o = {g1, g0} & {2{!cb_durdur_o && !rst_i}};
    aktar = |istek_hazir_o;
    cb_kontrol_o = g1 ? istek1_kontrol_i : istek0_kontrol_i;
    cb_deger1_o = g1 ? istek1_deger1_i : istek0_deger1_i;
    cb_deger2_o = g1 ? istek1_deger2_i : istek0_deger2_i;
    ptr_d = aktar ? istek_hazir_o[0] : ptr_q;
    gecerli_d = gecerli_q;
    sahip_d = sahip_q;
    etiket_d = etiket_q;
    if (!cb_durdur_o) begin
      for (int i = GECIKME - 1; i > 0; i--) begin
        gecerli_d[i] = gecerli_q[i-1];
        sahip_d[i] = sahip_q[i-1];
        etiket_d[i] = etiket_q[i-1];
      end
      gecerli_d[0] = aktar;
      sahip_d[0] = g1;
      etiket_d[0] = g1 ? istek1_etiket_i : istek0_etiket_i;
    end
    // flush kills requester-0 entries wherever they land after this edge
    gecerli_d = gecerli_d & ~({GECIKME{iptal_i}} & ~sahip_d);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gecerli_q <= '0;
      sahip_q <= '0;
      etiket_q <= '0;
      ptr_q <= 1'b0;
    end else begin
      gecerli_q <= gecerli_d;
      sahip_q <= sahip_d;
      etiket_q <= etiket_d;
      ptr_q <= ptr_d;
    end
  end
endmodule

// File: tb/tb_carpma_hakem.sv
// tb_carpma_hakem: directed bench for carpma_hakem with GECIKME=1 and GECIKME=3 instances and a multiplier model
module tb_carpma_hakem;
  typedef struct packed {
    logic [1:0]  k;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  t;
    logic [31:0] r;
  } op_t;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] val_a, val_b, rdy_a, rdy_b, sv_a, sv_b, sh;
  logic [1:0] k0, k1, cbk_a, cbk_b;
  logic [31:0] a0, b0, a1, b1, so_a, so_b, cbd1_a, cbd2_a, cbd1_b, cbd2_b, ma, cbs_b;
  logic [31:0] mb [3];
  logic [3:0] t0, t1, st_a, st_b;
  logic ipt, dur_a, dur_b;
  int n_chk = 0;
  int n_err = 0;
  op_t ops [6];
  int i0, i1;
  always #5 clk = ~clk;
  carpma_hakem #(.GECIKME(1), .ETIKET_W(4)) u_a (
    .clk_i(clk), .rst_i(rst), .istek_gecerli_i(val_a), .istek_hazir_o(rdy_a),
    .istek0_kontrol_i(k0), .istek0_deger1_i(a0), .istek0_deger2_i(b0), .istek0_etiket_i(t0),
    .istek1_kontrol_i(k1), .istek1_deger1_i(a1), .istek1_deger2_i(b1), .istek1_etiket_i(t1),
    .iptal_i(ipt), .sonuc_gecerli_o(sv_a), .sonuc_hazir_i(sh), .sonuc_o(so_a), .sonuc_etiket_o(st_a),
    .cb_durdur_o(dur_a), .cb_kontrol_o(cbk_a), .cb_deger1_o(cbd1_a), .cb_deger2_o(cbd2_a), .cb_sonuc_i(ma)
  );
  carpma_hakem #(.GECIKME(3), .ETIKET_W(4)) u_b (
    .clk_i(clk), .rst_i(rst), .istek_gecerli_i(val_b), .istek_hazir_o(rdy_b),
    .istek0_kontrol_i(k0), .istek0_deger1_i(a0), .istek0_deger2_i(b0), .istek0_etiket_i(t0),
    .istek1_kontrol_i(k1), .istek1_deger1_i(a1), .istek1_deger2_i(b1), .istek1_etiket_i(t1),
    .iptal_i(ipt), .sonuc_gecerli_o(sv_b), .sonuc_hazir_i(sh), .sonuc_o(so_b), .sonuc_etiket_o(st_b),
    .cb_durdur_o(dur_b), .cb_kontrol_o(cbk_b), .cb_deger1_o(cbd1_b), .cb_deger2_o(cbd2_b), .cb_sonuc_i(cbs_b)
  );
  function automatic logic [31:0] carp(input logic [1:0] k, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ss, su, uu;
    ss = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    su = {{32{a[31]}}, a} * {32'b0, b};
    uu = {32'b0, a} * {32'b0, b};
    return k == 2'd0 ? ss[31:0] : k == 2'd1 ? ss[63:32] : k == 2'd2 ? uu[63:32] : su[63:32];
  endfunction
  always @(posedge clk) if (!dur_a) ma <= carp(cbk_a, cbd1_a, cbd2_a);
  always @(posedge clk) begin
    if (!dur_b) begin
      mb[0] <= carp(cbk_b, cbd1_b, cbd2_b);
      mb[1] <= mb[0];
      mb[2] <= mb[1];
    end
  end
  assign cbs_b = mb[2];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set0(input op_t o);
    k0 = o.k; a0 = o.a; b0 = o.b; t0 = o.t;
  endtask
  task automatic set1(input op_t o);
    k1 = o.k; a1 = o.a; b1 = o.b; t1 = o.t;
  endtask
  initial begin
    ops[0] = '{2'd0, 32'd3, 32'd5, 4'd1, 32'd15};
    ops[1] = '{2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9, 32'hFFFFFFFE};
    ops[2] = '{2'd1, 32'h80000000, 32'h80000000, 4'd2, 32'h40000000};
    ops[3] = '{2'd0, 32'h00010000, 32'h00010000, 4'd10, 32'h0};
    ops[4] = '{2'd3, 32'hFFFFFFFF, 32'd2, 4'd4, 32'hFFFFFFFF};
    ops[5] = '{2'd2, 32'h00010000, 32'h00010000, 4'd11, 32'h1};
    rst = 1'b1; ipt = 1'b0; sh = 2'b11; val_a = 2'b01; val_b = 2'b00;
    set0('{2'd0, 32'd7, 32'hFFFFFFFD, 4'd3, 32'h0});
    set1('{2'd0, 32'd0, 32'd0, 4'd0, 32'h0});
    tick; tick;
    #1;
    chk("rst_sv", {30'b0, sv_a}, 32'h0);
    chk("rst_rdy", {30'b0, rdy_a}, 32'h0);
    chk("rst_dur", {31'b0, dur_a}, 32'h0);
    rst = 1'b0;
    #1;
    chk("t1_rdy", {30'b0, rdy_a}, 32'h1);
    tick;
    val_a = 2'b00;
    #1;
    chk("t1_sv", {30'b0, sv_a}, 32'h1);
    chk("t1_so", so_a, 32'hFFFFFFEB);
    chk("t1_tag", {28'b0, st_a}, 32'd3);
    tick;
    set1('{2'd0, 32'd3, 32'd3, 4'd2, 32'h0});
    val_a = 2'b10;
    #1;
    chk("rm_rdy", {30'b0, rdy_a}, 32'h2);
    tick;
    val_a = 2'b00; rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("rm_sv0", {30'b0, sv_a}, 32'h0);
    tick;
    chk("rm_sv1", {30'b0, sv_a}, 32'h0);
    chk("rm_dur", {31'b0, dur_a}, 32'h0);
    i0 = 0; i1 = 0;
    for (int c = 0; c < 7; c++) begin
      if (c < 6) begin
        set0(ops[2*i0]); set1(ops[2*i1+1]); val_a = 2'b11;
      end else val_a = 2'b00;
      #1;
      if (c < 6) chk($sformatf("rr_rdy%0d", c), {30'b0, rdy_a}, (c % 2 == 0) ? 32'h1 : 32'h2);
      if (c > 0) begin
        chk($sformatf("rr_sv%0d", c), {30'b0, sv_a}, ((c - 1) % 2 == 0) ? 32'h1 : 32'h2);
        chk($sformatf("rr_so%0d", c), so_a, ops[c-1].r);
        chk($sformatf("rr_tag%0d", c), {28'b0, st_a}, {28'b0, ops[c-1].t});
      end
      tick;
      if (c % 2 == 0) i0++; else i1++;
    end
    set1('{2'd0, 32'd6, 32'd7, 4'd5, 32'h0});
    val_a = 2'b10;
    #1;
    chk("bp_rdy_iss", {30'b0, rdy_a}, 32'h2);
    tick;
    set0('{2'd0, 32'd2, 32'd2, 4'd6, 32'h0});
    val_a = 2'b01; sh = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_dur%0d", c), {31'b0, dur_a}, 32'h1);
      chk($sformatf("bp_rdy%0d", c), {30'b0, rdy_a}, 32'h0);
      chk($sformatf("bp_sv%0d", c), {30'b0, sv_a}, 32'h2);
      chk($sformatf("bp_so%0d", c), so_a, 32'd42);
      chk($sformatf("bp_tag%0d", c), {28'b0, st_a}, 32'd5);
      tick;
    end
    sh = 2'b11;
    #1;
    chk("bp_rel_dur", {31'b0, dur_a}, 32'h0);
    chk("bp_rel_rdy", {30'b0, rdy_a}, 32'h1);
    chk("bp_rel_so", so_a, 32'd42);
    tick;
    val_a = 2'b00;
    #1;
    chk("bp_nxt_sv", {30'b0, sv_a}, 32'h1);
    chk("bp_nxt_so", so_a, 32'd4);
    chk("bp_nxt_tag", {28'b0, st_a}, 32'd6);
    tick;
    set0('{2'd0, 32'd9, 32'd9, 4'd7, 32'h0});
    val_a = 2'b01;
    #1;
    chk("fl_rdy_iss", {30'b0, rdy_a}, 32'h1);
    tick;
    set1('{2'd0, 32'd5, 32'd5, 4'd8, 32'h0});
    val_a = 2'b11; sh = 2'b10;
    #1;
    chk("fl_dur", {31'b0, dur_a}, 32'h1);
    chk("fl_rdy_st", {30'b0, rdy_a}, 32'h0);
    chk("fl_sv_st", {30'b0, sv_a}, 32'h1);
    chk("fl_so_st", so_a, 32'd81);
    tick;
    ipt = 1'b1;
    #1;
    chk("fl_dur_rel", {31'b0, dur_a}, 32'h0);
    chk("fl_sv_ipt", {30'b0, sv_a}, 32'h0);
    chk("fl_rdy_ipt", {30'b0, rdy_a}, 32'h2);
    tick;
    ipt = 1'b0; val_a = 2'b00; sh = 2'b11;
    #1;
    chk("fl_sv_r1", {30'b0, sv_a}, 32'h2);
    chk("fl_so_r1", so_a, 32'd25);
    chk("fl_tag_r1", {28'b0, st_a}, 32'd8);
    tick;
    chk("fl_sv_end", {30'b0, sv_a}, 32'h0);
    i0 = 0; i1 = 0;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        set0(ops[2*i0]); set1(ops[2*i1+1]); val_b = 2'b11;
      end else val_b = 2'b00;
      #1;
      if (c < 4) chk($sformatf("g3_rdy%0d", c), {30'b0, rdy_b}, (c % 2 == 0) ? 32'h1 : 32'h2);
      if (c < 3 || c == 7) chk($sformatf("g3_sv%0d", c), {30'b0, sv_b}, 32'h0);
      else begin
        chk($sformatf("g3_sv%0d", c), {30'b0, sv_b}, ((c - 3) % 2 == 0) ? 32'h1 : 32'h2);
        chk($sformatf("g3_so%0d", c), so_b, ops[c-3].r);
        chk($sformatf("g3_tag%0d", c), {28'b0, st_b}, {28'b0, ops[c-3].t});
      end
      tick;
      if (c % 2 == 0) i0++; else i1++;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
